prim_raster_writer: RTL and testbench
=====================================

# prim_raster_writer

Parametrised pixel back-end for the primitive renderer. It accepts a valid/ready stream of (x, y, last) pixel coordinates from the draw units (line, rectangle fill, triangle fill), clips each pixel against a programmable clip rectangle, and maps it into VRAM using a programmable base address, line stride and 4/8 bpp mode. Accepted writes are buffered in a FIFO and handed to the VRAM arbiter with an acknowledge handshake, so the draw units no longer lose pixels when VRAM is contended.

## Interface
- `CORDW`, 12: signed coordinate width. Minimum 12, because register payloads are 12 bits.
- `FIFO_DEPTH`, 4: write FIFO entries. Must be a power of two, ≥2.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `reset_i` in 1: synchronous, active-low reset.
- `cmd_i` in 16: register command; [15:12] opcode, [11:0] payload.
- `cmd_valid_i` in 1: `cmd_i` is valid this cycle.
- `pix_valid_i` in 1: pixel coordinate valid.
- `pix_ready_o` out 1: pixel is accepted when `pix_valid_i && pix_ready_o`.
- `pix_x_i`, `pix_y_i` in CORDW: signed pixel coordinate.
- `pix_last_i` in 1: final pixel of the current primitive.
- `vram_sel_o`, `vram_wr_o` out 1: a VRAM write request is pending (the two are always equal).
- `vram_mask_o` out 4: nibble write mask.
- `vram_addr_o` out 16: VRAM word address.
- `vram_data_o` out 16: write data.
- `vram_ack_i` in 1: arbiter accepted the current request.
- `busy_o` out 1: work is outstanding.
- `done_o` out 1: one-cycle pulse when a primitive is fully written.

## Operation
- Register opcodes (a write takes effect the cycle after `cmd_valid_i`):
  - 0 CLIP_X0, 1 CLIP_Y0, 2 CLIP_X1, 3 CLIP_Y1: payload sign-extended to CORDW.
  - 4 STRIDE: words per line, 12 bits unsigned.
  - 5 BASE_LO: sets base[11:0].
  - 6 BASE_HI: payload[3:0] sets base[15:12].
  - 7 COLOR: payload[7:0].
  - 8 MODE: payload[0]; 0 selects 8 bpp, 1 selects 4 bpp.
  - Opcodes 9–15 are ignored.
- Register reset values: clip (0,0)–(319,239), stride 160, base 0, color 0, mode 8 bpp.
- On acceptance, a pixel uses the register values current in that cycle. A command in the same cycle as an accepted pixel does not affect that pixel.
- Clip test (signed, inclusive): CLIP_X0 ≤ x ≤ CLIP_X1 and CLIP_Y0 ≤ y ≤ CLIP_Y1. Clipped pixels produce no write. Their `last` flag is still honoured.
- Address arithmetic, all modulo 2^16, using the low 12 bits of x and y:
  - 8 bpp: addr = base + y·stride + (x>>1); mask = x[0] ? 4'b0011 : 4'b1100; data = {color, color}.
  - 4 bpp: addr = base + y·stride + (x>>2); mask = 4'b1000 >> x[1:0]; data = {4{color[3:0]}}.
  - y·stride is a 12×12 product truncated to 16 bits.
- Pipeline: the accept cycle computes clip, address, mask and data into a single stage register. The next cycle pushes that entry into the FIFO (dropped if clipped).
- Output side:
  - `vram_sel_o`/`vram_wr_o` are high exactly while the FIFO is non-empty.
  - addr, mask and data show the FIFO head and stay stable until `vram_ack_i`; the ack pops the head.
  - When the FIFO is empty, the outputs hold their last value.
- Flow control: `pix_ready_o` = (fifo_count + stage_valid) < FIFO_DEPTH. It is computed from registered state, with no combinational path from `vram_ack_i`.
- Completion:
  - Accepting a pixel with `pix_last_i` sets `last_seen`.
  - `done_o` pulses for one cycle when `last_seen` is set, the stage is empty and the FIFO is empty. `last_seen` clears in the same cycle.
- `busy_o` = stage_valid | FIFO non-empty | `last_seen`.

## Timing
- All outputs are 0 in reset except `pix_ready_o`, which is 1 from the first cycle after reset.
- FIFO contents, stage, `last_seen` and all registers return to their reset values.
- Reset mid-operation discards queued writes and suppresses `done_o`.
- Latency: a pixel accepted in cycle N gives `vram_sel_o` = 1 in cycle N+2 if the FIFO was empty.
- Throughput: with `vram_ack_i` held high, one write per cycle is sustained.
- Ack while the FIFO is empty is ignored.
- Push and pop in the same cycle leave the count unchanged, including when the FIFO is full.
- A `last` pixel accepted at N with an empty FIFO and an ack at N+2 gives `done_o` at N+3. A clipped `last` pixel with an idle pipeline gives `done_o` at N+2.
- A new primitive may be accepted while `last_seen` is pending. If a second `last` is accepted before `done_o` fires, only one `done_o` pulse is produced.

## Configuration
- `PRIM_RASTER_CLIP_EN` defined: programmable clip rectangle as described above.
- `PRIM_RASTER_CLIP_EN` undefined:
  - Clip registers are not built and opcodes 0–3 are ignored.
  - Only pixels with negative x or y are dropped; all others are written.
  - Pipeline latency is unchanged.

## Test plan
- Default 8 bpp write: color 0x5A; pixel (3,2) with last; ack 1 cycle after sel → addr 0x0141, mask 0011, data 0x5A5A, `done_o` one cycle after the ack.
- 4 bpp with BASE_HI=0x8 and STRIDE=80: pixel (6,1), color 0x0C → addr 0x8051, mask 0010, data 0xCCCC.
- Clipping: CLIP (10,10)–(20,20); stream (9,10),(10,10),(20,21 last) → exactly one write at (10,10); `done_o` after it is acked.
- Backpressure: `vram_ack_i` = 0, stream 8 pixels → `pix_ready_o` drops after FIFO_DEPTH pixels are queued. Releasing ack drains all 8 in order with no loss or duplication.
- Reset (`reset_i` = 0) with 3 queued writes → sel/wr low the next cycle, no `done_o`, registers at defaults, `pix_ready_o` = 1.
- Address wrap: base 0xFFFF, pixel (0,0), 8 bpp → addr 0xFFFF; pixel (2,0) → addr 0x0000.

Source files
------------

// File: rtl/prim_raster_writer_if.sv
// Pixel-stream and VRAM write-port bundle of prim_raster_writer.
// master: the writer itself; slave: draw units and VRAM arbiter side.
interface prim_raster_writer_if #(
  parameter int unsigned CORDW = 12
);
  logic                    pix_valid_i;
  logic                    pix_ready_o;
  logic signed [CORDW-1:0] pix_x_i;
  logic signed [CORDW-1:0] pix_y_i;
  logic                    pix_last_i;

  logic                    vram_sel_o;
  logic                    vram_wr_o;
  logic [3:0]              vram_mask_o;
  logic [15:0]             vram_addr_o;
  logic [15:0]             vram_data_o;
  logic                    vram_ack_i;

  modport master (
    input  pix_valid_i, pix_x_i, pix_y_i, pix_last_i, vram_ack_i,
    output pix_ready_o, vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_o
  );

  modport slave (
    output pix_valid_i, pix_x_i, pix_y_i, pix_last_i, vram_ack_i,
    input  pix_ready_o, vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_o
  );
endinterface

// File: rtl/prim_raster_writer.sv
// Pixel back-end: clip (x,y), map to VRAM word/mask/data, queue writes for the arbiter.
// Define PRIM_RASTER_CLIP_EN to build the programmable clip rectangle.
module prim_raster_writer #(
  parameter int unsigned CORDW      = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic [15:0]          cmd_i,
  input  logic                 cmd_valid_i,
  prim_raster_writer_if.master bus,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned REG_W  = 12;
  localparam int unsigned ADDR_W = 16;

`ifdef PRIM_RASTER_CLIP_EN
  localparam logic [3:0] OP_CLIP_X0 = 4'd0;
  localparam logic [3:0] OP_CLIP_Y0 = 4'd1;
  localparam logic [3:0] OP_CLIP_X1 = 4'd2;
  localparam logic [3:0] OP_CLIP_Y1 = 4'd3;
`endif
  localparam logic [3:0] OP_STRIDE  = 4'd4;
  localparam logic [3:0] OP_BASE_LO = 4'd5;
  localparam logic [3:0] OP_BASE_HI = 4'd6;
  localparam logic [3:0] OP_COLOR   = 4'd7;
  localparam logic [3:0] OP_MODE    = 4'd8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        mask;
    logic [15:0]       data;
  } wr_entry_t;

  // Configuration registers
  logic [REG_W-1:0]  stride_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        color_q;
  logic              mode_q;
`ifdef PRIM_RASTER_CLIP_EN
  logic signed [CORDW-1:0] clip_x0_q, clip_y0_q, clip_x1_q, clip_y1_q;
`endif

  logic [3:0]       cmd_op;
  logic [REG_W-1:0] cmd_pay;
  assign cmd_op  = cmd_i[15:12];
  assign cmd_pay = cmd_i[REG_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      stride_q  <= REG_W'(160);
      base_q    <= '0;
      color_q   <= '0;
      mode_q    <= 1'b0;
`ifdef PRIM_RASTER_CLIP_EN
      clip_x0_q <= '0;
      clip_y0_q <= '0;
      clip_x1_q <= CORDW'(319);
      clip_y1_q <= CORDW'(239);
`endif
    end else if (cmd_valid_i) begin
      case (cmd_op)
`ifdef PRIM_RASTER_CLIP_EN
        OP_CLIP_X0: clip_x0_q <= CORDW'($signed(cmd_pay));
        OP_CLIP_Y0: clip_y0_q <= CORDW'($signed(cmd_pay));
        OP_CLIP_X1: clip_x1_q <= CORDW'($signed(cmd_pay));
        OP_CLIP_Y1: clip_y1_q <= CORDW'($signed(cmd_pay));
`endif
        OP_STRIDE:  stride_q       <= cmd_pay;
        OP_BASE_LO: base_q[11:0]   <= cmd_pay;
        OP_BASE_HI: base_q[15:12]  <= cmd_pay[3:0];
        OP_COLOR:   color_q        <= cmd_pay[7:0];
        OP_MODE:    mode_q         <= cmd_pay[0];
        default:    ;
      endcase
    end
  end

  // Address/mask/data and clip decision for the pixel offered this cycle
  logic [REG_W-1:0]  x_lo, y_lo;
  logic [ADDR_W-1:0] line_off;
  wr_entry_t         pix_entry;
  logic              pix_clip;

  assign x_lo = bus.pix_x_i[REG_W-1:0];
  assign y_lo = bus.pix_y_i[REG_W-1:0];

  always_comb begin
    line_off = ADDR_W'(y_lo) * ADDR_W'(stride_q);
    if (mode_q) begin
      pix_entry.addr = base_q + line_off + ADDR_W'(x_lo[REG_W-1:2]);
      pix_entry.mask = 4'b1000 >> x_lo[1:0];
      pix_entry.data = {4{color_q[3:0]}};
    end else begin
      pix_entry.addr = base_q + line_off + ADDR_W'(x_lo[REG_W-1:1]);
      pix_entry.mask = x_lo[0] ? 4'b0011 : 4'b1100;
      pix_entry.data = {2{color_q}};
    end
`ifdef PRIM_RASTER_CLIP_EN
    pix_clip = (bus.pix_x_i < clip_x0_q) || (bus.pix_x_i > clip_x1_q) ||
               (bus.pix_y_i < clip_y0_q) || (bus.pix_y_i > clip_y1_q);
`else
    pix_clip = bus.pix_x_i[CORDW-1] | bus.pix_y_i[CORDW-1];
`endif
  end

  // Pipeline / FIFO state
  logic             stage_valid_q, stage_clip_q;
  wr_entry_t        stage_q;
  wr_entry_t        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             last_seen_q;
  logic             ready_q, sel_q, busy_q, done_q;
  wr_entry_t        head_q;

  logic             accept, push, pop;
  logic [CNT_W-1:0] count_d;
  logic [PTR_W-1:0] wr_ptr_d, rd_ptr_d;
  logic             last_seen_d, ready_d, sel_d, busy_d, done_d;
  wr_entry_t        head_d;

  // Next state; outputs are precomputed so every port comes straight from a flop
  always_comb begin
    accept   = bus.pix_valid_i & ready_q;
    push     = stage_valid_q & ~stage_clip_q;
    pop      = (count_q != '0) & bus.vram_ack_i;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    head_d   = head_q;
    // When the only remaining entry is the one being pushed, bypass the memory
    if (count_d != '0) begin
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? stage_q : fifo_mem[rd_ptr_d];
    end
    done_d      = last_seen_q & ~accept & (count_d == '0);
    last_seen_d = done_d ? 1'b0 : (last_seen_q | (accept & bus.pix_last_i));
    ready_d     = (SUM_W'(count_d) + SUM_W'(accept)) < SUM_W'(FIFO_DEPTH);
    sel_d       = (count_d != '0);
    busy_d      = accept | sel_d | last_seen_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      stage_valid_q <= 1'b0;
      stage_clip_q  <= 1'b0;
      stage_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      last_seen_q   <= 1'b0;
      ready_q       <= 1'b1;
      sel_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      head_q        <= '0;
    end else begin
      stage_valid_q <= accept;
      if (accept) begin
        stage_q      <= pix_entry;
        stage_clip_q <= pix_clip;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_seen_q <= last_seen_d;
      ready_q     <= ready_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      head_q      <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i && push) begin
      fifo_mem[wr_ptr_q] <= stage_q;
    end
  end

  assign bus.pix_ready_o = ready_q;
  assign bus.vram_sel_o  = sel_q;
  assign bus.vram_wr_o   = sel_q;
  assign bus.vram_addr_o = head_q.addr;
  assign bus.vram_mask_o = head_q.mask;
  assign bus.vram_data_o = head_q.data;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_prim_raster_writer.sv
// Directed self-checking bench for prim_raster_writer (both clip build options).
module tb_prim_raster_writer;

  localparam int unsigned CORDW      = 12;
  localparam int unsigned FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] cmd_i;
  logic        cmd_valid_i;
  logic        busy_o, done_o;

  prim_raster_writer_if #(.CORDW(CORDW)) bus ();

  prim_raster_writer #(.CORDW(CORDW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .cmd_i       (cmd_i),
    .cmd_valid_i (cmd_valid_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int          sx[$], sy[$];
  logic        sl[$];
  logic [15:0] exp_addr[$], exp_data[$], got_addr[$], got_data[$];
  logic [3:0]  exp_mask[$], got_mask[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] op, input logic [11:0] pay);
    cmd_i       = {op, pay};
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    cmd_i       = '0;
  endtask

  task automatic drive_pix(input int x, input int y, input logic last);
    bus.pix_valid_i = 1'b1;
    bus.pix_x_i     = CORDW'(x);
    bus.pix_y_i     = CORDW'(y);
    bus.pix_last_i  = last;
  endtask

  task automatic apply_reset();
    reset_i          = 1'b0;
    bus.pix_valid_i  = 1'b0;
    bus.vram_ack_i   = 1'b0;
    tick();
    reset_i = 1'b1;
  endtask

  task automatic clear_q();
    sx.delete(); sy.delete(); sl.delete();
    exp_addr.delete(); exp_mask.delete(); exp_data.delete();
    got_addr.delete(); got_mask.delete(); got_data.delete();
  endtask

  task automatic add_pix(input int x, input int y, input logic last);
    sx.push_back(x); sy.push_back(y); sl.push_back(last);
  endtask

  task automatic add_exp(input logic [15:0] a, input logic [3:0] m, input logic [15:0] d);
    exp_addr.push_back(a); exp_mask.push_back(m); exp_data.push_back(d);
  endtask

  // Offer queued pixels from index 'first'; ack every pending write; count done pulses
  task automatic stream(input int first, input int budget, output int ndone);
    int idx;
    idx   = first;
    ndone = 0;
    for (int c = 0; c < budget; c++) begin
      if (idx < sx.size()) begin
        drive_pix(sx[idx], sy[idx], sl[idx]);
        if (bus.pix_ready_o) idx++;
      end else begin
        bus.pix_valid_i = 1'b0;
      end
      if (bus.vram_sel_o) begin
        got_addr.push_back(bus.vram_addr_o);
        got_mask.push_back(bus.vram_mask_o);
        got_data.push_back(bus.vram_data_o);
        bus.vram_ack_i = 1'b1;
      end else begin
        bus.vram_ack_i = 1'b0;
      end
      tick();
      if (done_o) ndone++;
    end
    bus.pix_valid_i = 1'b0;
    bus.vram_ack_i  = 1'b0;
    check("stream_accepted", 32'(idx), 32'(sx.size()));
  endtask

  task automatic verify_writes(input string tag);
    check($sformatf("%s_count", tag), 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s_mask%0d", tag, i), 32'(got_mask[i]), 32'(exp_mask[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int nd;
    reset_i         = 1'b0;
    cmd_i           = '0;
    cmd_valid_i     = 1'b0;
    bus.pix_valid_i = 1'b0;
    bus.pix_x_i     = '0;
    bus.pix_y_i     = '0;
    bus.pix_last_i  = 1'b0;
    bus.vram_ack_i  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_sel",   32'(bus.vram_sel_o),  32'd0);
    check("rst_wr",    32'(bus.vram_wr_o),   32'd0);
    check("rst_addr",  32'(bus.vram_addr_o), 32'd0);
    check("rst_mask",  32'(bus.vram_mask_o), 32'd0);
    check("rst_data",  32'(bus.vram_data_o), 32'd0);
    check("rst_busy",  32'(busy_o),          32'd0);
    check("rst_done",  32'(done_o),          32'd0);
    check("rst_ready", 32'(bus.pix_ready_o), 32'd1);
    reset_i = 1'b1;
    tick();

    // Default 8 bpp write with latency and done timing
    cmd(4'd7, 12'h05A);
    check("t1_ready", 32'(bus.pix_ready_o), 32'd1);
    drive_pix(3, 2, 1'b1);
    tick();
    bus.pix_valid_i = 1'b0;
    check("t1_n1_sel",  32'(bus.vram_sel_o), 32'd0);
    check("t1_n1_busy", 32'(busy_o),         32'd1);
    tick();
    check("t1_sel",  32'(bus.vram_sel_o),  32'd1);
    check("t1_wr",   32'(bus.vram_wr_o),   32'd1);
    check("t1_addr", 32'(bus.vram_addr_o), 32'h0141);
    check("t1_mask", 32'(bus.vram_mask_o), 32'b0011);
    check("t1_data", 32'(bus.vram_data_o), 32'h5A5A);
    tick();
    check("t1_hold_sel",  32'(bus.vram_sel_o),  32'd1);
    check("t1_hold_addr", 32'(bus.vram_addr_o), 32'h0141);
    check("t1_early_done", 32'(done_o), 32'd0);
    bus.vram_ack_i = 1'b1;
    tick();
    bus.vram_ack_i = 1'b0;
    check("t1_pop_sel",  32'(bus.vram_sel_o),  32'd0);
    check("t1_done",     32'(done_o),          32'd1);
    check("t1_busy",     32'(busy_o),          32'd0);
    check("t1_keep_addr", 32'(bus.vram_addr_o), 32'h0141);
    tick();
    check("t1_done_pulse", 32'(done_o), 32'd0);

    // 4 bpp with BASE_HI and STRIDE
    cmd(4'd6, 12'h008);
    cmd(4'd4, 12'd80);
    cmd(4'd7, 12'h00C);
    cmd(4'd8, 12'h001);
    drive_pix(6, 1, 1'b0);
    tick();
    bus.pix_valid_i = 1'b0;
    tick();
    check("t2_sel",  32'(bus.vram_sel_o),  32'd1);
    check("t2_addr", 32'(bus.vram_addr_o), 32'h8051);
    check("t2_mask", 32'(bus.vram_mask_o), 32'b0010);
    check("t2_data", 32'(bus.vram_data_o), 32'hCCCC);
    bus.vram_ack_i = 1'b1;
    tick();
    bus.vram_ack_i = 1'b0;
    check("t2_pop_sel", 32'(bus.vram_sel_o), 32'd0);
    check("t2_no_done", 32'(done_o),         32'd0);

    // Clipping (opcodes 0-3 are ignored when the clip rectangle is not built)
    apply_reset();
    cmd(4'd0, 12'd10);
    cmd(4'd1, 12'd10);
    cmd(4'd2, 12'd20);
    cmd(4'd3, 12'd20);
    cmd(4'd7, 12'h033);
    clear_q();
`ifdef PRIM_RASTER_CLIP_EN
    add_pix(9, 10, 1'b0);
    add_pix(10, 10, 1'b0);
    add_pix(20, 21, 1'b1);
    add_exp(16'h0645, 4'b1100, 16'h3333);
`else
    add_pix(9, 10, 1'b0);
    add_pix(-1, 4, 1'b0);
    add_pix(10, 10, 1'b0);
    add_pix(5, -3, 1'b0);
    add_pix(20, 21, 1'b1);
    add_exp(16'h0644, 4'b0011, 16'h3333);
    add_exp(16'h0645, 4'b1100, 16'h3333);
    add_exp(16'h0D2A, 4'b1100, 16'h3333);
`endif
    stream(0, 20, nd);
    verify_writes("clip");
    check("clip_done", 32'(nd), 32'd1);

    // Backpressure: ack held low, then drain in order
    apply_reset();
    cmd(4'd7, 12'h0A5);
    clear_q();
    for (int i = 0; i < 8; i++) begin
      add_pix(2 * i + 1, i, i == 7);
      add_exp(16'(161 * i), 4'b0011, 16'hA5A5);
    end
    idx = 0;
    for (int c = 0; c < 20 && idx < 8; c++) begin
      if (!bus.pix_ready_o) break;
      drive_pix(sx[idx], sy[idx], sl[idx]);
      idx++;
      tick();
    end
    bus.pix_valid_i = 1'b0;
    check("bp_queued", 32'(idx), 32'(FIFO_DEPTH));
    repeat (3) tick();
    check("bp_ready_low", 32'(bus.pix_ready_o), 32'd0);
    check("bp_sel",       32'(bus.vram_sel_o),  32'd1);
    check("bp_head_addr", 32'(bus.vram_addr_o), 32'h0000);
    stream(idx, 40, nd);
    verify_writes("bp");
    check("bp_done", 32'(nd), 32'd1);

    // Reset with queued writes
    apply_reset();
    cmd(4'd7, 12'h077);
    cmd(4'd8, 12'h001);
    cmd(4'd6, 12'h003);
    cmd(4'd4, 12'd7);
    for (int i = 0; i < 3; i++) begin
      drive_pix(i + 1, 1, i == 2);
      tick();
    end
    bus.pix_valid_i = 1'b0;
    tick();
    tick();
    check("rm_pre_sel", 32'(bus.vram_sel_o), 32'd1);
    reset_i = 1'b0;
    tick();
    check("rm_sel",   32'(bus.vram_sel_o),  32'd0);
    check("rm_wr",    32'(bus.vram_wr_o),   32'd0);
    check("rm_busy",  32'(busy_o),          32'd0);
    check("rm_done",  32'(done_o),          32'd0);
    check("rm_ready", 32'(bus.pix_ready_o), 32'd1);
    reset_i = 1'b1;
    nd = 0;
    repeat (5) begin
      tick();
      if (done_o) nd++;
    end
    check("rm_no_done",  32'(nd),             32'd0);
    check("rm_idle_sel", 32'(bus.vram_sel_o), 32'd0);
    clear_q();
    add_pix(3, 2, 1'b1);
    add_exp(16'h0141, 4'b0011, 16'h0000);
    stream(0, 12, nd);
    verify_writes("rm_defaults");
    check("rm_after_done", 32'(nd), 32'd1);

    // Address wrap at 2^16
    apply_reset();
    cmd(4'd5, 12'hFFF);
    cmd(4'd6, 12'h00F);
    cmd(4'd7, 12'h001);
    clear_q();
    add_pix(0, 0, 1'b0);
    add_pix(2, 0, 1'b1);
    add_exp(16'hFFFF, 4'b1100, 16'h0101);
    add_exp(16'h0000, 4'b1100, 16'h0101);
    stream(0, 16, nd);
    verify_writes("wrap");
    check("wrap_done", 32'(nd), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
